// File: rtl/bisect_pkg.sv
// Shared definitions for the bisection root-search sequencer.
package bisect_pkg;

    localparam int W_DEF        = 8;
    localparam int MAX_ITER_DEF = 8;
    localparam int ADD_LAT_DEF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MID  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Halving both bounds drops their LSBs; the sum only needs a +1
    // correction when both dropped bits were set.
    function automatic logic carry_fix(input logic lo_lsb, input logic hi_lsb);
        return lo_lsb & hi_lsb;
    endfunction

endpackage

// File: rtl/bisect_mid.sv
// Midpoint formation around the shared adder: operands are the halved
// bounds, the midpoint is the adder sum plus the LSB carry correction.
// floor((lo+hi)/2) formed this way never overflows W bits.
module bisect_mid import bisect_pkg::*; #(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] lo_nx,
    input  logic [W-1:0] hi_nx,
    input  logic         lo_lsb,
    input  logic         hi_lsb,
    input  logic [W-1:0] add_sum,
    output logic [W-1:0] op_a_nx,
    output logic [W-1:0] op_b_nx,
    output logic [W-1:0] mid
);

    assign op_a_nx = lo_nx >> 1;
    assign op_b_nx = hi_nx >> 1;
    assign mid     = add_sum + {{(W-1){1'b0}}, carry_fix(lo_lsb, hi_lsb)};

endmodule

// File: rtl/bisect_ctrl.sv
// Bisection root-search sequencer: drives the shared adder to form each
// midpoint, requests f(mid) from an external evaluator and narrows the
// [lo, hi] bracket until a zero is hit or the bracket collapses.
module bisect_ctrl import bisect_pkg::*; #(
    parameter int W        = W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ADD_LAT  = ADD_LAT_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] lo_init,
    input  logic [W-1:0] hi_init,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_sum,
    output logic         f_req,
    output logic [W-1:0] f_x,
    input  logic         f_ack,
    input  logic         f_pos,
    input  logic         f_zero,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] root,
    output logic         err,
    output logic [3:0]   iters
);

    localparam int              CW       = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [CW-1:0]   LAT_LAST = CW'(ADD_LAT);
    localparam logic [3:0]      ITER_CAP = 4'(MAX_ITER);

    state_t          state_r;
    logic [W-1:0]    lo_r;
    logic [W-1:0]    hi_r;
    logic [CW-1:0]   lat_cnt_r;
    logic [W-1:0]    lo_nx_s;
    logic [W-1:0]    hi_nx_s;
    logic [W-1:0]    op_a_nx_s;
    logic [W-1:0]    op_b_nx_s;
    logic [W-1:0]    mid_s;

    // Bracket the next MID phase will use: the fresh bounds when leaving
    // IDLE, otherwise the bounds after applying the pending evaluation.
    always_comb begin
        lo_nx_s = lo_r;
        hi_nx_s = hi_r;
        if (state_r == ST_IDLE) begin
            lo_nx_s = lo_init;
            hi_nx_s = hi_init;
        end else if (f_pos) begin
            hi_nx_s = f_x;
        end else begin
            lo_nx_s = f_x;
        end
    end

    bisect_mid #(.W(W)) u_mid (
        .lo_nx   (lo_nx_s),
        .hi_nx   (hi_nx_s),
        .lo_lsb  (lo_r[0]),
        .hi_lsb  (hi_r[0]),
        .add_sum (add_sum),
        .op_a_nx (op_a_nx_s),
        .op_b_nx (op_b_nx_s),
        .mid     (mid_s)
    );

    // Search sequencer with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            lo_r      <= {W{1'b0}};
            hi_r      <= {W{1'b0}};
            lat_cnt_r <= {CW{1'b0}};
            add_a     <= {W{1'b0}};
            add_b     <= {W{1'b0}};
            f_req     <= 1'b0;
            f_x       <= {W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            root      <= {W{1'b0}};
            err       <= 1'b0;
            iters     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        lo_r      <= lo_init;
                        hi_r      <= hi_init;
                        iters     <= 4'd0;
                        root      <= {W{1'b0}};
                        lat_cnt_r <= {CW{1'b0}};
                        busy      <= 1'b1;
                        if (lo_init > hi_init) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            err     <= 1'b0;
                            add_a   <= op_a_nx_s;
                            add_b   <= op_b_nx_s;
                            state_r <= ST_MID;
                        end
                    end
                end
                ST_MID: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        lat_cnt_r <= {CW{1'b0}};
                        add_a     <= {W{1'b0}};
                        add_b     <= {W{1'b0}};
                        if ((mid_s == lo_r) || (iters == ITER_CAP)) begin
                            root    <= lo_r;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            f_x     <= mid_s;
                            f_req   <= 1'b1;
                            state_r <= ST_EVAL;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + CW'(1);
                    end
                end
                ST_EVAL: begin
                    if (f_ack) begin
                        f_req <= 1'b0;
                        f_x   <= {W{1'b0}};
                        if (iters != ITER_CAP) begin
                            iters <= iters + 4'd1;
                        end
                        if (f_zero) begin
                            root    <= f_x;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            lo_r    <= lo_nx_s;
                            hi_r    <= hi_nx_s;
                            add_a   <= op_a_nx_s;
                            add_b   <= op_b_nx_s;
                            state_r <= ST_MID;
                        end
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    f_req   <= 1'b0;
                    add_a   <= {W{1'b0}};
                    add_b   <= {W{1'b0}};
                    f_x     <= {W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bisect_ctrl.sv
// Self-checking bench for bisect_ctrl: one instance with a combinational
// adder (ADD_LAT=0) and one with a registered adder (ADD_LAT=1), each
// searched against a bracket/iteration reference model.
module tb_bisect_ctrl;

    localparam int MAX_ITER = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       start_0, f_ack_0, f_pos_0, f_zero_0, f_req_0, busy_0, done_0, err_0;
    logic [7:0] lo_init_0, hi_init_0, add_a_0, add_b_0, add_sum_0, f_x_0, root_0;
    logic [3:0] iters_0;
    logic       start_1, f_ack_1, f_pos_1, f_zero_1, f_req_1, busy_1, done_1, err_1;
    logic [7:0] lo_init_1, hi_init_1, add_a_1, add_b_1, add_sum_1, f_x_1, root_1;
    logic [3:0] iters_1;

    bisect_ctrl #(.W(8), .MAX_ITER(MAX_ITER), .ADD_LAT(0)) u_dut0 (
        .clock(clock), .reset(reset), .start(start_0), .lo_init(lo_init_0), .hi_init(hi_init_0),
        .add_a(add_a_0), .add_b(add_b_0), .add_sum(add_sum_0), .f_req(f_req_0), .f_x(f_x_0),
        .f_ack(f_ack_0), .f_pos(f_pos_0), .f_zero(f_zero_0), .busy(busy_0), .done(done_0),
        .root(root_0), .err(err_0), .iters(iters_0));

    bisect_ctrl #(.W(8), .MAX_ITER(MAX_ITER), .ADD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start_1), .lo_init(lo_init_1), .hi_init(hi_init_1),
        .add_a(add_a_1), .add_b(add_b_1), .add_sum(add_sum_1), .f_req(f_req_1), .f_x(f_x_1),
        .f_ack(f_ack_1), .f_pos(f_pos_1), .f_zero(f_zero_1), .busy(busy_1), .done(done_1),
        .root(root_1), .err(err_1), .iters(iters_1));

    // Adder models: combinational for instance 0, one-cycle registered for instance 1.
    assign add_sum_0 = add_a_0 + add_b_0;
    always @(posedge clock or negedge reset) begin
        if (!reset) add_sum_1 <= 8'd0;
        else        add_sum_1 <= add_a_1 + add_b_1;
    end

    // Observation view of whichever instance is under test.
    int         sel = 0;
    logic       v_busy, v_done, v_freq, v_err;
    logic [7:0] v_fx, v_root, v_adda, v_addb;
    logic [3:0] v_iters;
    always_comb begin
        if (sel == 1) begin
            v_busy = busy_1; v_done = done_1; v_freq = f_req_1; v_err = err_1;
            v_fx = f_x_1; v_root = root_1; v_adda = add_a_1; v_addb = add_b_1; v_iters = iters_1;
        end else begin
            v_busy = busy_0; v_done = done_0; v_freq = f_req_0; v_err = err_0;
            v_fx = f_x_0; v_root = root_0; v_adda = add_a_0; v_addb = add_b_0; v_iters = iters_0;
        end
    end

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    int got_q[$];
    int m_root, m_iters;
    bit m_err, m_zero_end;

    task automatic drive(input logic st, input logic [7:0] lo, input logic [7:0] hi,
                         input logic ack, input logic pos, input logic zero);
        if (sel == 1) begin
            start_1 = st; lo_init_1 = lo; hi_init_1 = hi; f_ack_1 = ack; f_pos_1 = pos; f_zero_1 = zero;
            start_0 = 1'b0; lo_init_0 = 8'd0; hi_init_0 = 8'd0; f_ack_0 = 1'b0; f_pos_0 = 1'b0; f_zero_0 = 1'b0;
        end else begin
            start_0 = st; lo_init_0 = lo; hi_init_0 = hi; f_ack_0 = ack; f_pos_0 = pos; f_zero_0 = zero;
            start_1 = 1'b0; lo_init_1 = 8'd0; hi_init_1 = 8'd0; f_ack_1 = 1'b0; f_pos_1 = 1'b0; f_zero_1 = 1'b0;
        end
    endtask

    // Evaluator: mode 0 is f(x)=x-tgt, mode 1 is positive for x>=tgt and never zero.
    // Returns 0 for zero, 1 for positive, 2 for negative.
    function automatic int resp(input int mode, input int tgt, input int x);
        if (mode == 0) return (x == tgt) ? 0 : ((x > tgt) ? 1 : 2);
        return (x >= tgt) ? 1 : 2;
    endfunction

    // Reference bisection over integers.
    task automatic model(input int lo, input int hi, input int mode, input int tgt);
        int l, h, m, r;
        bit fin;
        l = lo; h = hi; fin = 0;
        exp_q.delete();
        m_root = 0; m_iters = 0; m_err = 0; m_zero_end = 0;
        if (lo > hi) begin
            m_err = 1;
            fin = 1;
        end
        while (!fin) begin
            m = (l + h) / 2;
            if (m == l || m_iters == MAX_ITER) begin
                m_root = l;
                fin = 1;
            end else begin
                exp_q.push_back(m);
                m_iters++;
                r = resp(mode, tgt, m);
                if (r == 0) begin
                    m_root = m; m_zero_end = 1; fin = 1;
                end else if (r == 1) begin
                    h = m;
                end else begin
                    l = m;
                end
            end
        end
    endtask

    // One complete search on instance d; expects to be called at a negedge and
    // returns at the negedge just after busy falls (so calls run back to back).
    // Cycle labels count the start cycle as cycle 1.
    task automatic run_search(input int d, input int lo, input int hi, input int mode,
                              input int tgt, input int delay, input bit poke, input bit junk,
                              input string name);
        int req_cnt, done_lbl, first_req, done_cnt, n_mid, exp_done, r, cyc;
        logic [7:0] held;
        logic st, ack, pos, zero;
        bit fin;
        sel = d;
        model(lo, hi, mode, tgt);
        got_q.delete();
        req_cnt = 0; done_lbl = -1; first_req = -1; done_cnt = 0; fin = 0; held = 8'd0;
        drive(1'b1, 8'(lo), 8'(hi), 1'b0, 1'b0, 1'b0);
        cyc = 1;
        while (!fin && cyc < 400) begin
            @(negedge clock);
            cyc++;
            st = 1'b0; ack = 1'b0; pos = 1'b0; zero = 1'b0;
            if (v_freq) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    got_q.push_back(int'(v_fx));
                    held = v_fx;
                    if (first_req < 0) first_req = cyc;
                end else begin
                    total++;
                    if (v_fx !== held) begin
                        bad++; $display("FAIL %s fx_stable: got %0d want %0d", name, v_fx, held);
                    end
                end
                total++;
                if (v_adda !== 8'd0 || v_addb !== 8'd0) begin
                    bad++; $display("FAIL %s add_zero_in_eval: got a=%0d b=%0d want 0", name, v_adda, v_addb);
                end
                if (req_cnt == delay + 1) begin
                    r = resp(mode, tgt, int'(v_fx));
                    ack = 1'b1; pos = (r == 1); zero = (r == 0);
                end
                st = poke && (req_cnt == 2);
            end else begin
                req_cnt = 0;
                if (junk) begin
                    ack = 1'($urandom % 2); pos = 1'($urandom % 2); zero = 1'($urandom % 2);
                end
            end
            if (v_done) begin
                done_cnt++;
                if (done_lbl < 0) begin
                    done_lbl = cyc;
                    total++;
                    if (v_busy !== 1'b1) begin
                        bad++; $display("FAIL %s busy_at_done: got %0d want 1", name, v_busy);
                    end
                end
            end
            if (done_lbl >= 0 && cyc == done_lbl + 1) fin = 1;
            drive(st, poke ? 8'd7 : 8'(lo), poke ? 8'd3 : 8'(hi), ack, pos, zero);
        end
        total++;
        if (!fin) begin
            bad++; $display("FAIL %s timeout: got no done within %0d cycles want done", name, cyc);
        end else begin
            n_mid    = m_err ? 0 : exp_q.size() + (m_zero_end ? 0 : 1);
            exp_done = 2 + n_mid * (d + 1) + exp_q.size() * (delay + 1);
            total++;
            if (got_q.size() != exp_q.size()) begin
                bad++; $display("FAIL %s eval_count: got %0d want %0d", name, got_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    total++;
                    if (got_q[i] != exp_q[i]) begin
                        bad++; $display("FAIL %s f_x[%0d]: got %0d want %0d", name, i, got_q[i], exp_q[i]);
                    end
                end
            end
            total++;
            if (v_root !== 8'(m_root)) begin
                bad++; $display("FAIL %s root: got %0d want %0d", name, v_root, m_root);
            end
            total++;
            if (v_iters !== 4'(m_iters)) begin
                bad++; $display("FAIL %s iters: got %0d want %0d", name, v_iters, m_iters);
            end
            total++;
            if (v_err !== m_err) begin
                bad++; $display("FAIL %s err: got %0d want %0d", name, v_err, m_err);
            end
            total++;
            if (done_lbl != exp_done) begin
                bad++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_lbl, exp_done);
            end
            total++;
            if (done_cnt != 1 || v_done !== 1'b0 || v_busy !== 1'b0) begin
                bad++; $display("FAIL %s done_pulse: got pulses=%0d done=%0d busy=%0d want 1,0,0",
                                name, done_cnt, v_done, v_busy);
            end
            total++;
            if (first_req != (exp_q.size() > 0 ? d + 3 : -1)) begin
                bad++; $display("FAIL %s first_req_cycle: got %0d want %0d", name, first_req,
                                exp_q.size() > 0 ? d + 3 : -1);
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            total++;
            if ({v_busy, v_done, v_freq, v_err, v_fx, v_root, v_adda, v_addb, v_iters} !== 40'd0) begin
                bad++; $display("FAIL reset_state dut%0d: got busy=%0d done=%0d req=%0d err=%0d fx=%0d root=%0d iters=%0d want all 0",
                                d, v_busy, v_done, v_freq, v_err, v_fx, v_root, v_iters);
            end
        end
        sel = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_zero_hit();
        int ref_seq[8] = '{127, 63, 95, 111, 103, 99, 101, 100};
        run_search(0, 0, 255, 0, 100, 0, 1'b0, 1'b0, "zero_hit");
        total++;
        if (got_q.size() != 8) begin
            bad++; $display("FAIL zero_hit_len: got %0d want 8", got_q.size());
        end else begin
            foreach (ref_seq[i]) begin
                total++;
                if (got_q[i] != ref_seq[i]) begin
                    bad++; $display("FAIL zero_hit_seq[%0d]: got %0d want %0d", i, got_q[i], ref_seq[i]);
                end
            end
        end
    endtask

    task automatic test_no_zero();
        run_search(0, 0, 255, 1, 101, 0, 1'b0, 1'b0, "no_zero");
        run_search(1, 0, 255, 1, 101, 0, 1'b0, 1'b0, "no_zero_lat1");
    endtask

    task automatic test_boundaries();
        run_search(0, 200, 10, 0, 100, 0, 1'b0, 1'b0, "err_order");
        run_search(1, 42, 42, 0, 42, 0, 1'b0, 1'b0, "degenerate_lat1");
        run_search(0, 42, 43, 0, 42, 0, 1'b0, 1'b0, "adjacent");
    endtask

    task automatic test_delayed_ack();
        run_search(0, 0, 255, 0, 100, 5, 1'b1, 1'b0, "delay5_lat0");
        run_search(1, 0, 255, 0, 100, 5, 1'b1, 1'b0, "delay5_lat1");
    endtask

    task automatic test_reset_mid_eval();
        int i;
        sel = 0;
        drive(1'b1, 8'd0, 8'd255, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 8'd0, 8'd255, 1'b0, 1'b0, 1'b0);
        i = 0;
        while (!v_freq && i < 20) begin
            @(negedge clock);
            i++;
        end
        total++;
        if (v_freq !== 1'b1) begin
            bad++; $display("FAIL rst_req_seen: got %0d want 1", v_freq);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({v_busy, v_done, v_freq, v_err, v_fx, v_root, v_adda, v_addb, v_iters} !== 40'd0) begin
            bad++; $display("FAIL rst_mid_eval: got busy=%0d req=%0d fx=%0d root=%0d want all 0",
                            v_busy, v_freq, v_fx, v_root);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if (v_done !== 1'b0 || v_busy !== 1'b0) begin
                bad++; $display("FAIL rst_hold: got done=%0d busy=%0d want 0,0", v_done, v_busy);
            end
        end
        reset = 1'b1;
        run_search(0, 0, 255, 0, 100, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int lo, hi, d;
        for (int n = 0; n < 24; n++) begin
            lo = $urandom_range(0, 255);
            hi = $urandom_range(0, 255);
            if (($urandom % 8) != 0 && lo > hi) begin
                d = lo; lo = hi; hi = d;
            end
            d = int'($urandom % 2);
            run_search(d, lo, hi, int'($urandom % 2), $urandom_range(0, 255),
                       $urandom_range(0, 3), 1'($urandom % 2), 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_zero_hit();
        test_no_zero();
        test_boundaries();
        test_delayed_ack();
        test_reset_mid_eval();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bisect_ctrl.md
# bisect_ctrl

Sequencer that runs an integer bisection root search on a monotonically increasing function. It shares the project's 8-bit adder datapath (operand A, operand B, sum) to form each midpoint. Function values are obtained from an external evaluator over a request/acknowledge handshake. It sits in the user project beside the adder: it drives the adder operands, sequences iterations, and reports the final root and status.

## Interface
- `W`, 8, data/search width; matches the adder operand width.
- `MAX_ITER`, 8, maximum function evaluations per search.
- `ADD_LAT`, 0, adder latency in cycles (0 = combinational sum).

- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch a search; honoured only in IDLE.
- `lo_init`  in  W  lower bound; f(lo_init) ≤ 0 by contract.
- `hi_init`  in  W  upper bound; f(hi_init) > 0 by contract.
- `add_a`  out  W  adder operand A.
- `add_b`  out  W  adder operand B.
- `add_sum`  in  W  adder result.
- `f_req`  out  1  evaluation request; held until acknowledged.
- `f_x`  out  W  evaluation point; stable while `f_req`=1.
- `f_ack`  in  1  evaluator response valid.
- `f_pos`  in  1  f(f_x) > 0; sampled with `f_ack`.
- `f_zero`  in  1  f(f_x) == 0; sampled with `f_ack`; takes priority over `f_pos`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `root`  out  W  result; held until the next accepted `start`.
- `err`  out  1  lo_init > hi_init; held like `root`.
- `iters`  out  4  completed evaluations; held like `root`.

## Operation
- States: IDLE, MID, EVAL, DONE.
- **IDLE**
  - `start`=1 latches lo/hi and clears iters, root and err.
  - If lo_init > hi_init: set err=1, root=0, go to DONE.
  - Otherwise go to MID.
- **MID** (midpoint)
  - Drive `add_a`=lo>>1 and `add_b`=hi>>1; hold them for ADD_LAT+1 cycles.
  - On the last of those cycles: mid = add_sum + (lo[0] & hi[0]). This equals floor((lo+hi)/2) and cannot overflow.
  - If mid == lo (hi−lo ≤ 1) or iters == MAX_ITER: root=lo, go to DONE.
  - Otherwise register f_x=mid and go to EVAL.
- **EVAL**
  - `f_req`=1 with `f_x` stable until `f_ack`=1 is sampled.
  - On ack, iters increments, then:
    - f_zero: root=f_x, go to DONE.
    - f_pos: hi=f_x, go to MID.
    - otherwise: lo=f_x, go to MID.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- `add_a`/`add_b` are 0 outside MID; `f_x` is 0 outside EVAL.
- `start` while busy is ignored. `f_ack` outside EVAL is ignored.
- Arithmetic is unsigned W-bit. iters saturates at MAX_ITER, which is ≤ 15.

## Timing
- Reset values: state=IDLE; busy, done, f_req, err = 0; add_a, add_b, f_x, root, iters = 0; internal lo/hi = 0.
- Reset asserted mid-search returns immediately to IDLE, with `f_req` and `busy` low asynchronously. No `done` is produced.
- Start to first `f_req`: ADD_LAT+2 cycles (1 cycle in IDLE, ADD_LAT+1 cycles in MID).
- Per iteration: ADD_LAT+1 MID cycles plus EVAL cycles; EVAL is at least 1 cycle (ack in the first EVAL cycle).
- Error and degenerate inputs (lo > hi, or lo == hi): `done` arrives 2 or ADD_LAT+3 cycles after `start`, with no `f_req`.
- `busy` falls in the cycle after the `done` pulse. A new `start` is accepted in that same cycle.

## Structure
- Shared package `bisect_pkg`:
  - state enum type;
  - default constants for W, MAX_ITER, ADD_LAT.
- The midpoint formation (operand shift plus carry-fix) is a natural sub-module `bisect_mid`, wrapping the adder port connection.
- Everything else lives in one FSM module.

## Test plan
- f(x)=x−100, lo=0, hi=255, ack in the first EVAL cycle:
  - f_x sequence 127, 63, 95, 111, 103, 99, 101, 100;
  - f_zero at 100 → root=100, iters=8, err=0, one `done` pulse.
- f_pos = (x ≥ 101), f_zero never, lo=0, hi=255:
  - same first seven points, then 100 (negative) → lo=100, hi=101;
  - next MID gives mid == lo → root=100, iters=8.
- lo=200, hi=10 → `done` 2 cycles after `start`, err=1, root=0, `f_req` never asserted.
- lo=hi=42, ADD_LAT=1 → `done` at cycle 4, root=42, iters=0, no `f_req`.
- Ack delayed 5 cycles:
  - `f_x` stable and `f_req` high throughout;
  - `start` pulsed while busy has no effect;
  - `add_a`/`add_b` are 0 during EVAL.
- `reset` low during EVAL:
  - `f_req` and `busy` drop the same cycle, all outputs 0;
  - a fresh search (lo=0, hi=255, f(x)=x−100) then completes with root=100.
